comparator: RTL and testbench
=============================

// Module: comparator
//
// PURPOSE
//   Cascadable magnitude-comparator slice with a registered result. Compares local
//   operands A and B, then merges the result with a cascade status (EQ, GT) from the
//   more-significant stage. The merged result is the result for the whole word.
//   Chains of slices build wide comparators; slice results are registered once per stage.
//
// PARAMETERS
//   WIDTH   1   operand width of this slice in bits (>=1)
//   SIGNED  0   1: A/B are two's-complement (slice holds the word MSB); 0: unsigned
//
// PORTS
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous, active-high reset
//   A       in   WIDTH  local operand A
//   B       in   WIDTH  local operand B
//   EQ      in   1      cascade: higher-order bits equal (top stage ties to 1)
//   GT      in   1      cascade: higher-order A > B (meaningful only when EQ=0)
//   S       out  1      registered word result: A > B (equals GT_OUT)
//   EQ_OUT  out  1      registered word result: A == B; feeds EQ of next lower stage
//   GT_OUT  out  1      registered word result: A > B; feeds GT of next lower stage
//   LT_OUT  out  1      registered word result: A < B
//
// BEHAVIOUR
//   - Local compare (combinational): lgt=(A>B), leq=(A==B), llt=(A<B);
//     unsigned if SIGNED=0, two's-complement if SIGNED=1.
//   - Merge: EQ=1 -> {GT_OUT,EQ_OUT,LT_OUT} = {lgt,leq,llt} (GT input ignored);
//     EQ=0 -> EQ_OUT=0, GT_OUT=GT, LT_OUT=~GT (local operands ignored).
//   - EQ=1 dominates: EQ=1,GT=1 is legal and GT is ignored.
//   - S = GT_OUT at all times.
//   - Latency: exactly 1 clk. Inputs sampled at edge N appear on outputs after edge N.
//     New result every cycle; no handshake and no stall.
//   - Exactly one of GT_OUT/EQ_OUT/LT_OUT is 1 whenever not in reset.
//   - Reset: at any edge with rst=1, S=GT_OUT=EQ_OUT=LT_OUT=0. Reset wins over inputs.
//     The first valid result appears one edge after rst deasserts. Mid-stream reset
//     discards the in-flight result.
//   - Boundaries: A=B=all-ones and A=B=0 with EQ=1 -> EQ_OUT=1.
//     SIGNED=1: MSB set compares less than MSB clear.
//   - No X propagation on outputs after reset. All outputs driven from flops only.
//
// STRUCTURE
//   - Shared package cmp_pkg: typedef cmp_res_t {LT, EQ, GT} (2-bit enum).
//   - cmp_pkg also holds function merge(cmp_res_t local, eq_in, gt_in), reused by wide
//     comparators.
//   - One combinational sub-module: cmp_core (WIDTH, SIGNED; A, B -> cmp_res_t).
//   - Top level: cmp_core, then merge, then the output register.
//
// TESTING
//   1. rst=1 for 2 clk with A=1,B=1,EQ=1 -> all outputs 0. First result 1 clk after release.
//   2. WIDTH=1, EQ=1,GT=1,A=1,B=1 -> EQ_OUT=1,S=0,LT_OUT=0. A=0,B=0 -> EQ_OUT=1.
//   3. WIDTH=1, EQ=0,GT=1 for A/B in {01,10,00,11} -> S=1,GT_OUT=1,EQ_OUT=0 every cycle.
//      Repeat with EQ=0,GT=0 -> LT_OUT=1.
//   4. WIDTH=1, EQ=1: A=1,B=0 -> S=1. A=0,B=1 -> LT_OUT=1. Check each result is 1 clk delayed.
//   5. WIDTH=8, SIGNED=1, EQ=1: A=8'h80,B=8'h7F -> LT_OUT=1.
//      Same operands with SIGNED=0 -> GT_OUT=1.
//   6. Random A/B/EQ/GT, 1000 cycles, against a reference model:
//      outputs one-hot, and S==GT_OUT every cycle.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and the cascade merge function for magnitude comparator slices.
`default_nettype none

package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_t;

  // A higher-order stage that is not equal decides the word; otherwise the local slice does.
  function automatic cmp_res_t merge(cmp_res_t loc_res, logic eq_in, logic gt_in);
    cmp_res_t res;
    if (eq_in) begin
      res = loc_res;
    end else if (gt_in) begin
      res = CMP_GT;
    end else begin
      res = CMP_LT;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_core.sv
// Combinational magnitude compare of one slice's operands, signed or unsigned.
`default_nettype none

module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output cmp_res_t         res_o
);

  logic lgt;

  generate
    if (SIGNED) begin : g_signed
      assign lgt = $signed(a_i) > $signed(b_i);
    end else begin : g_unsigned
      assign lgt = a_i > b_i;
    end
  endgenerate

  always_comb begin
    res_o = CMP_LT;
    if (a_i == b_i) begin
      res_o = CMP_EQ;
    end else if (lgt) begin
      res_o = CMP_GT;
    end
  end

endmodule

`default_nettype wire

// File: rtl/comparator.sv
// Cascadable magnitude comparator slice: local compare, cascade merge, one register stage.
`default_nettype none

module comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             EQ,
  input  logic             GT,
  output logic             S,
  output logic             EQ_OUT,
  output logic             GT_OUT,
  output logic             LT_OUT
);

  cmp_res_t core_res;
  cmp_res_t merged_d;
  logic     gt_q;
  logic     eq_q;
  logic     lt_q;

  cmp_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .a_i   (A),
    .b_i   (B),
    .res_o (core_res)
  );

  assign merged_d = merge(core_res, EQ, GT);

  // Flags are stored unpacked so reset can hold all three low, which the enum cannot encode.
  always_ff @(posedge clk) begin
    if (rst) begin
      gt_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      gt_q <= (merged_d == CMP_GT);
      eq_q <= (merged_d == CMP_EQ);
      lt_q <= (merged_d == CMP_LT);
    end
  end

  assign S      = gt_q;
  assign GT_OUT = gt_q;
  assign EQ_OUT = eq_q;
  assign LT_OUT = lt_q;

endmodule

`default_nettype wire

// File: tb/tb_comparator.sv
// Self-checking bench: three comparator configurations against an arithmetic reference model.
`default_nettype none

module tb_comparator;

  logic       clk;
  logic       rst;
  logic       eq_in;
  logic       gt_in;
  logic       a1, b1;
  logic [7:0] a8, b8;

  logic s1, eqo1, gto1, lto1;
  logic ss, eqos, gtos, ltos;
  logic su, eqou, gtou, ltou;

  int checks = 0;
  int errors = 0;

  comparator #(.WIDTH(1), .SIGNED(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .EQ(eq_in), .GT(gt_in),
    .S(s1), .EQ_OUT(eqo1), .GT_OUT(gto1), .LT_OUT(lto1)
  );

  comparator #(.WIDTH(8), .SIGNED(1'b1)) u_w8s (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .EQ(eq_in), .GT(gt_in),
    .S(ss), .EQ_OUT(eqos), .GT_OUT(gtos), .LT_OUT(ltos)
  );

  comparator #(.WIDTH(8), .SIGNED(1'b0)) u_w8u (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .EQ(eq_in), .GT(gt_in),
    .S(su), .EQ_OUT(eqou), .GT_OUT(gtou), .LT_OUT(ltou)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {S,GT_OUT,EQ_OUT,LT_OUT} from integer operand values.
  function automatic logic [3:0] model(int a, int b, logic eq, logic gt, logic in_rst);
    if (in_rst) return 4'b0000;
    if (eq) begin
      if (a > b) return 4'b1100;
      if (a == b) return 4'b0010;
      return 4'b0001;
    end
    return gt ? 4'b1100 : 4'b0001;
  endfunction

  function automatic int as_signed8(logic [7:0] v);
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock once, then compare all three slices one cycle later.
  task automatic step(string tag, logic r, logic va1, logic vb1,
                      logic [7:0] va8, logic [7:0] vb8, logic veq, logic vgt);
    logic [3:0] e1, es, eu;
    rst = r; a1 = va1; b1 = vb1; a8 = va8; b8 = vb8; eq_in = veq; gt_in = vgt;
    e1 = model(int'(va1), int'(vb1), veq, vgt, r);
    es = model(as_signed8(va8), as_signed8(vb8), veq, vgt, r);
    eu = model(int'(va8), int'(vb8), veq, vgt, r);
    @(posedge clk);
    #1;
    chk({tag, "_w1"},  {s1, gto1, eqo1, lto1}, e1);
    chk({tag, "_w8s"}, {ss, gtos, eqos, ltos}, es);
    chk({tag, "_w8u"}, {su, gtou, eqou, ltou}, eu);
  endtask

  initial begin
    logic [1:0] ab;
    rst = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'd1; b8 = 8'd1; eq_in = 1'b1; gt_in = 1'b0;

    // Reset held two cycles with equal operands: outputs stay low.
    step("rst0", 1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 1'b1, 1'b0);
    step("rst1", 1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 1'b1, 1'b0);
    step("first", 1'b0, 1'b1, 1'b1, 8'd1, 8'd1, 1'b1, 1'b0);

    // EQ dominates GT; all-ones and zero equality.
    step("eqgt_ones", 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    step("eq_zero",   1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);

    // Cascade not equal: local operands ignored.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      step("casc_gt", 1'b0, ab[1], ab[0], {8{ab[1]}}, {8{ab[0]}}, 1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      step("casc_lt", 1'b0, ab[1], ab[0], {8{ab[1]}}, {8{ab[0]}}, 1'b0, 1'b0);
    end

    // Local decides; each result must correspond to the immediately preceding edge.
    step("loc_gt", 1'b0, 1'b1, 1'b0, 8'h10, 8'h01, 1'b1, 1'b0);
    step("loc_lt", 1'b0, 1'b0, 1'b1, 8'h01, 8'h10, 1'b1, 1'b0);
    step("loc_gt2", 1'b0, 1'b1, 1'b0, 8'h02, 8'h01, 1'b1, 1'b0);

    // Sign boundary: 0x80 vs 0x7F differs between signed and unsigned slices.
    step("sign_bnd", 1'b0, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b1, 1'b0);
    step("sign_bnd2", 1'b0, 1'b1, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b0);

    // Mid-stream reset discards the in-flight result, then recovers.
    step("mid_rst", 1'b1, 1'b1, 1'b0, 8'h90, 8'h10, 1'b1, 1'b0);
    step("post_rst", 1'b0, 1'b0, 1'b1, 8'h90, 8'h10, 1'b1, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      step("rand", 1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom));
      chk("onehot_w1",  {3'b000, $onehot({gto1, eqo1, lto1})}, 4'b0001);
      chk("onehot_w8s", {3'b000, $onehot({gtos, eqos, ltos})}, 4'b0001);
      chk("onehot_w8u", {3'b000, $onehot({gtou, eqou, ltou})}, 4'b0001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
